// File: rtl/ffpmac_wb_ctrl.sv
// Wishbone-classic register front end for an FFPMAC: operand registers, latency FSM and result FIFO.
// Define FFPMAC_CTRL_IRQ_EN to build the registered result-available interrupt; otherwise irq is tied 0.
module ffpmac_wb_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    output logic [31:0] mac_c,
    output logic [1:0]  mac_rnd,
    input  logic [31:0] mac_result,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [2:0] IDX_OPAB   = 3'd0;
    localparam logic [2:0] IDX_OPC    = 3'd1;
    localparam logic [2:0] IDX_CTRL   = 3'd2;
    localparam logic [2:0] IDX_STATUS = 3'd3;
    localparam logic [2:0] IDX_RESULT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [15:0]   a_q, b_q;
    logic [31:0]   c_q;
    logic [1:0]    rnd_q;
    logic [3:0]    lat_q;
    logic          ovf_q, busy_err_q;
    logic          ack_q;
    logic [31:0]   dat_q;
    logic [31:0]   fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic        access, wr_en, rd_en, busy;
    logic        fifo_empty, fifo_full, pop, push, push_ok;
    logic [2:0]  idx;
    logic [31:0] status, rd_data;
    logic        unused_adr;

    assign access     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr_en      = access & wbs_we_i;
    assign rd_en      = access & ~wbs_we_i;
    assign idx        = wbs_adr_i[4:2];
    assign busy       = (state_q != ST_IDLE);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign pop        = rd_en & (idx == IDX_RESULT) & ~fifo_empty;
    assign push       = (state_q == ST_CAPTURE);
    // A same-edge pop frees a slot, so a push into a full FIFO still lands.
    assign push_ok    = push & (~fifo_full | pop);
    assign status     = {23'd0, 4'(count_q), busy_err_q, ovf_q, fifo_full, fifo_empty, busy};
    assign unused_adr = &{1'b0, wbs_adr_i[31:5], wbs_adr_i[1:0]};

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign mac_a     = a_q;
    assign mac_b     = b_q;
    assign mac_c     = c_q;
    assign mac_rnd   = rnd_q;

    // NOTE: assigning a default before the case keeps this block purely combinational (no latch).
    always_comb begin
        rd_data = '0;
        case (idx)
            IDX_OPAB:   rd_data = {b_q, a_q};
            IDX_OPC:    rd_data = c_q;
            IDX_CTRL:   rd_data = {24'd0, lat_q, 1'b0, rnd_q, 1'b0};
            IDX_STATUS: rd_data = status;
            IDX_RESULT: rd_data = fifo_empty ? 32'd0 : fifo_q[rd_ptr_q];
            default:    rd_data = '0;
        endcase
    end

    // NOTE: non-blocking assignments make every register below see only pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            rnd_q      <= '0;
            lat_q      <= '0;
            ovf_q      <= 1'b0;
            busy_err_q <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            ack_q <= access;
            dat_q <= rd_en ? rd_data : 32'd0;

            if (wr_en && idx == IDX_STATUS) begin
                if (wbs_dat_i[3]) ovf_q <= 1'b0;
                if (wbs_dat_i[4]) busy_err_q <= 1'b0;
            end
            // Placed after the clear so a same-edge set wins.
            if (push && !push_ok) ovf_q <= 1'b1;
            if (wr_en && busy && idx <= IDX_CTRL) busy_err_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (wr_en) begin
                        case (idx)
                            IDX_OPAB: begin
                                a_q <= wbs_dat_i[15:0];
                                b_q <= wbs_dat_i[31:16];
                            end
                            IDX_OPC: c_q <= wbs_dat_i;
                            IDX_CTRL: begin
                                rnd_q <= wbs_dat_i[2:1];
                                lat_q <= wbs_dat_i[7:4];
                                if (wbs_dat_i[0]) begin
                                    state_q <= ST_WAIT;
                                    cnt_q   <= (wbs_dat_i[7:4] == 4'd0) ? 4'd1 : wbs_dat_i[7:4];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase

            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= mac_result;
    end

`ifdef FFPMAC_CTRL_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= ~fifo_empty | ovf_q;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
